// File: rtl/mcr_rom_loader.sv
// MCR1 download front-end: routes ioctl ROM bytes to the dpram, latches module/DIP bytes,
// tracks load status and sequences the core reset (held through load, then a delayed extra pulse).
module mcr_rom_loader #(
  parameter int          ROM_AW    = 16,
  parameter logic [15:0] HOLD_CNT  = 16'hFFFF,
  parameter logic [7:0]  MOD_INDEX = 8'd1,
  parameter logic [7:0]  DIP_INDEX = 8'd254
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  input  logic [7:0]        ioctl_index,
  input  logic              user_reset,
  output logic              rom_we,
  output logic [ROM_AW-1:0] rom_waddr,
  output logic [7:0]        rom_wdata,
  output logic              rom_download,
  output logic [7:0]        mod_id,
  output logic              mod_valid,
  output logic [63:0]       dip_bus,
  output logic              rom_loaded,
  output logic [ROM_AW:0]   rom_bytes,
  output logic              load_error,
  output logic              core_reset
);

  typedef enum logic [2:0] {S_EMPTY, S_LOAD, S_SETTLE, S_RUN, S_UHOLD} state_t;

  localparam logic [ROM_AW:0] BYTES_MAX = {1'b1, {ROM_AW{1'b0}}};
  localparam logic [ROM_AW:0] BYTES_ONE = {{ROM_AW{1'b0}}, 1'b1};

  state_t              r_state;
  logic [15:0]         r_cnt;
  logic                r_core_reset;
  logic                r_dl, r_dl_d;
  logic                r_rom_we;
  logic [ROM_AW-1:0]   r_rom_waddr;
  logic [7:0]          r_rom_wdata;
  logic [7:0]          r_mod_id;
  logic                r_mod_valid;
  logic [63:0]         r_dip;
  logic                r_rom_loaded;
  logic [ROM_AW:0]     r_rom_bytes;
  logic                r_ovf;
  logic                r_load_error;

  state_t              w_state_nxt;
  logic [15:0]         w_cnt_nxt;
  logic                w_core_reset_nxt;
  logic                w_load_entry, w_load_done, w_load_fail;

  wire w_idx0      = (ioctl_index == 8'd0);
  wire w_in_range  = (ioctl_addr[24:ROM_AW] == '0);
  wire w_rom_wr    = ioctl_wr && ioctl_download && w_idx0;
  wire w_accept    = w_rom_wr && w_in_range;
  wire w_drop      = w_rom_wr && !w_in_range;
  wire w_dl_rise   = r_dl && !r_dl_d;
  wire w_dl_fall   = !r_dl && r_dl_d;

  // Completion looks at the count including a byte accepted in the same cycle.
  wire [ROM_AW:0] w_bytes_eff = (w_accept && (r_rom_bytes != BYTES_MAX)) ?
                                r_rom_bytes + BYTES_ONE : r_rom_bytes;
  wire            w_ovf_eff   = r_ovf || w_drop;
  wire            w_load_bad  = (w_bytes_eff == '0) || w_ovf_eff;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_state      <= S_EMPTY;
      r_cnt        <= HOLD_CNT;
      r_core_reset <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_core_reset <= w_core_reset_nxt;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_EMPTY: if (w_dl_rise) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (w_dl_fall) begin
          if (w_load_bad) begin
            w_state_nxt = S_EMPTY;
          end else begin
            w_state_nxt = S_SETTLE;
            w_cnt_nxt   = HOLD_CNT;
          end
        end
      end
      default: begin
        if (w_dl_rise) begin
          w_state_nxt = S_LOAD;
        end else if (user_reset) begin
          w_state_nxt = S_UHOLD;
          w_cnt_nxt   = HOLD_CNT;
        end else if (r_state == S_UHOLD) begin
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = HOLD_CNT;
        end else if (r_state == S_SETTLE) begin
          if (r_cnt <= 16'd1) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = 16'd0;
          end else begin
            w_cnt_nxt   = r_cnt - 16'd1;
          end
        end
      end
    endcase
  end

  // core_reset is registered from the next state so it tracks the state register exactly.
  always_comb begin
    w_core_reset_nxt = 1'b0;
    unique case (w_state_nxt)
      S_EMPTY, S_LOAD, S_UHOLD: w_core_reset_nxt = 1'b1;
      S_SETTLE:                 w_core_reset_nxt = (w_cnt_nxt == 16'd1);
      default:                  w_core_reset_nxt = 1'b0;
    endcase
    w_load_entry = (w_state_nxt == S_LOAD) && (r_state != S_LOAD);
    w_load_done  = (r_state == S_LOAD) && (w_state_nxt == S_SETTLE);
    w_load_fail  = (r_state == S_LOAD) && (w_state_nxt == S_EMPTY);
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      r_dl         <= 1'b0;
      r_dl_d       <= 1'b0;
      r_rom_we     <= 1'b0;
      r_rom_waddr  <= '0;
      r_rom_wdata  <= '0;
      r_mod_id     <= '0;
      r_mod_valid  <= 1'b0;
      r_dip        <= '0;
      r_rom_loaded <= 1'b0;
      r_rom_bytes  <= '0;
      r_ovf        <= 1'b0;
      r_load_error <= 1'b0;
    end else begin
      r_dl     <= ioctl_download && w_idx0;
      r_dl_d   <= r_dl;
      r_rom_we <= w_accept;
      if (w_accept) begin
        r_rom_waddr <= ioctl_addr[ROM_AW-1:0];
        r_rom_wdata <= ioctl_dout;
      end
      if (w_load_entry) begin
        r_rom_bytes  <= w_accept ? BYTES_ONE : '0;
        r_ovf        <= w_drop;
        r_load_error <= 1'b0;
        r_rom_loaded <= 1'b0;
      end else begin
        r_rom_bytes <= w_bytes_eff;
        r_ovf       <= w_ovf_eff;
        if (w_load_done) r_rom_loaded <= 1'b1;
        if (w_load_fail) r_load_error <= 1'b1;
      end
      if (ioctl_wr && (ioctl_index == MOD_INDEX) && (ioctl_addr == 25'd0)) begin
        r_mod_id    <= ioctl_dout;
        r_mod_valid <= 1'b1;
      end
      if (ioctl_wr && (ioctl_index == DIP_INDEX) && (ioctl_addr[24:3] == '0))
        r_dip[{ioctl_addr[2:0], 3'b000} +: 8] <= ioctl_dout;
    end
  end

  assign rom_we       = r_rom_we;
  assign rom_waddr    = r_rom_waddr;
  assign rom_wdata    = r_rom_wdata;
  assign rom_download = r_dl;
  assign mod_id       = r_mod_id;
  assign mod_valid    = r_mod_valid;
  assign dip_bus      = r_dip;
  assign rom_loaded   = r_rom_loaded;
  assign rom_bytes    = r_rom_bytes;
  assign load_error   = r_load_error;
  assign core_reset   = r_core_reset;

endmodule

// File: tb/tb_mcr_rom_loader.sv
// Bench for mcr_rom_loader: scoreboard on ROM writes, table of module/DIP vectors,
// and hand-written sequences for load completion, overflow, user reset and mid-load reset.
module tb_mcr_rom_loader;
  localparam int          AW   = 12;
  localparam logic [15:0] HOLD = 16'd20;
  localparam int          BUDGET = 500;

  logic          clk_sys = 1'b0;
  logic          reset_n;
  logic          ioctl_download, ioctl_wr, user_reset;
  logic [24:0]   ioctl_addr;
  logic [7:0]    ioctl_dout, ioctl_index;
  logic          rom_we, rom_download, mod_valid, rom_loaded, load_error, core_reset;
  logic [AW-1:0] rom_waddr;
  logic [7:0]    rom_wdata, mod_id;
  logic [63:0]   dip_bus;
  logic [AW:0]   rom_bytes;

  mcr_rom_loader #(.ROM_AW(AW), .HOLD_CNT(HOLD), .MOD_INDEX(8'd1), .DIP_INDEX(8'd254)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_index(ioctl_index),
    .user_reset(user_reset), .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
    .rom_download(rom_download), .mod_id(mod_id), .mod_valid(mod_valid), .dip_bus(dip_bus),
    .rom_loaded(rom_loaded), .rom_bytes(rom_bytes), .load_error(load_error),
    .core_reset(core_reset));

  always #5 clk_sys = ~clk_sys;

  typedef struct { logic [AW-1:0] addr; logic [7:0] data; int due; } exp_wr_t;
  typedef struct {
    logic [7:0] idx; logic [24:0] addr; logic [7:0] data;
    logic [7:0] e_mod; logic e_valid; logic [63:0] e_dip;
  } vec_t;

  exp_wr_t q[$];
  vec_t    vecs[6];
  int      n_tests = 0;
  int      n_fail  = 0;
  int      cyc     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: outputs sampled at the falling edge, then new inputs may be driven.
  task automatic step();
    exp_wr_t e;
    @(posedge clk_sys);
    @(negedge clk_sys);
    cyc++;
    if (rom_we || (q.size() != 0 && q[0].due <= cyc)) begin
      if (q.size() == 0) begin
        check("rom_we_spurious", 64'(rom_we), 64'd0);
      end else begin
        e = q.pop_front();
        check("rom_write", {11'd0, 32'(cyc), rom_we, 12'(rom_waddr), rom_wdata},
                           {11'd0, 32'(e.due), 1'b1, 12'(e.addr), e.data});
      end
    end
  endtask

  task automatic drive_byte(input logic [24:0] addr, input logic [7:0] data);
    exp_wr_t e;
    ioctl_wr = 1'b1; ioctl_addr = addr; ioctl_dout = data;
    if (reset_n && ioctl_download && ioctl_index == 8'd0 && addr < 25'(1 << AW)) begin
      e.addr = addr[AW-1:0]; e.data = data; e.due = cyc + 1;
      q.push_back(e);
    end
    step();
    ioctl_wr = 1'b0;
  endtask

  task automatic rom_load(input int n);
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    repeat (3) step();
    for (int i = 0; i < n; i++) begin
      ioctl_wr = 1'b1;
      drive_byte(25'(i), 8'(i));
    end
    ioctl_download = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rom_we"},     64'(rom_we), 64'd0);
    check({tag, "_rom_waddr"},  64'(rom_waddr), 64'd0);
    check({tag, "_rom_wdata"},  64'(rom_wdata), 64'd0);
    check({tag, "_rom_dl"},     64'(rom_download), 64'd0);
    check({tag, "_mod_id"},     64'(mod_id), 64'd0);
    check({tag, "_mod_valid"},  64'(mod_valid), 64'd0);
    check({tag, "_dip_bus"},    dip_bus, 64'd0);
    check({tag, "_rom_loaded"}, 64'(rom_loaded), 64'd0);
    check({tag, "_rom_bytes"},  64'(rom_bytes), 64'd0);
    check({tag, "_load_error"}, 64'(load_error), 64'd0);
    check({tag, "_core_reset"}, 64'(core_reset), 64'd1);
  endtask

  // Expects optional leading high cycles, then HOLD-1 low, exactly one high, then low.
  task automatic check_pulse(input string nm, input int exp_lead);
    int lead = 0, lo = 0, hi = 0, late = 0;
    step();
    while (core_reset && lead < BUDGET) begin lead++; step(); end
    while (!core_reset && lo < BUDGET) begin lo++; step(); end
    while (core_reset && hi < BUDGET) begin hi++; step(); end
    for (int i = 0; i < 8; i++) begin
      if (core_reset) late++;
      step();
    end
    if (exp_lead >= 0) check({nm, "_lead_high"}, 64'(lead), 64'(exp_lead));
    check({nm, "_low_cycles"},  64'(lo), 64'(HOLD - 16'd1));
    check({nm, "_pulse_width"}, 64'(hi), 64'd1);
    check({nm, "_high_after"},  64'(late), 64'd0);
  endtask

  initial begin
    int highs;
    vecs[0] = '{8'd1,   25'd0, 8'h01, 8'h01, 1'b1, 64'h0};
    vecs[1] = '{8'd1,   25'd5, 8'h07, 8'h01, 1'b1, 64'h0};
    vecs[2] = '{8'd254, 25'd3, 8'hA5, 8'h01, 1'b1, 64'h0000_0000_A500_0000};
    vecs[3] = '{8'd254, 25'd8, 8'h3C, 8'h01, 1'b1, 64'h0000_0000_A500_0000};
    vecs[4] = '{8'd254, 25'd0, 8'h11, 8'h01, 1'b1, 64'h0000_0000_A500_0011};
    vecs[5] = '{8'd254, 25'd7, 8'hEE, 8'h01, 1'b1, 64'hEE00_0000_A500_0011};

    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0;
    ioctl_dout = '0; ioctl_index = '0; user_reset = 1'b0;
    repeat (3) step();
    check_reset_vals("rst");
    reset_n = 1'b1;
    repeat (2) step();

    // Module and DIP latching from the EMPTY state; none of it touches core_reset.
    ioctl_download = 1'b1;
    for (int i = 0; i < 6; i++) begin
      ioctl_index = vecs[i].idx;
      drive_byte(vecs[i].addr, vecs[i].data);
      check($sformatf("vec%0d_mod_id", i),    64'(mod_id), 64'(vecs[i].e_mod));
      check($sformatf("vec%0d_mod_valid", i), 64'(mod_valid), 64'(vecs[i].e_valid));
      check($sformatf("vec%0d_dip_bus", i),   dip_bus, vecs[i].e_dip);
      check($sformatf("vec%0d_core_reset", i), 64'(core_reset), 64'd1);
      check($sformatf("vec%0d_rom_dl", i),    64'(rom_download), 64'd0);
    end
    ioctl_download = 1'b0;
    repeat (3) step();
    check("nonrom_rom_bytes", 64'(rom_bytes), 64'd0);

    // Half-size good load, then the settle pulse.
    rom_load(1 << (AW - 1));
    check_pulse("load", -1);
    check("load_rom_bytes",  64'(rom_bytes), 64'(1 << (AW - 1)));
    check("load_rom_loaded", 64'(rom_loaded), 64'd1);
    check("load_error_ok",   64'(load_error), 64'd0);
    check("load_queue_empty", 64'(q.size()), 64'd0);

    // User reset held 10 cycles in RUN.
    user_reset = 1'b1;
    highs = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (core_reset) highs++;
    end
    check("ureset_high_cycles", 64'(highs), 64'd10);
    user_reset = 1'b0;
    check_pulse("ureset", 0);
    check("ureset_rom_loaded", 64'(rom_loaded), 64'd1);

    // Overflowing load: two bytes past the ROM space are dropped.
    rom_load((1 << AW) + 2);
    repeat (4) step();
    check("ovf_rom_bytes",  64'(rom_bytes), 64'(1 << AW));
    check("ovf_load_error", 64'(load_error), 64'd1);
    check("ovf_rom_loaded", 64'(rom_loaded), 64'd0);
    highs = 0;
    for (int i = 0; i < 3 * HOLD; i++) begin
      if (core_reset) highs++;
      step();
    end
    check("ovf_core_reset_held", 64'(highs), 64'(3 * HOLD));
    check("ovf_queue_empty", 64'(q.size()), 64'd0);

    // Empty download.
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    repeat (3) step();
    ioctl_download = 1'b0;
    repeat (4) step();
    check("empty_load_error", 64'(load_error), 64'd1);
    check("empty_rom_bytes",  64'(rom_bytes), 64'd0);
    check("empty_rom_loaded", 64'(rom_loaded), 64'd0);
    highs = 0;
    for (int i = 0; i < 2 * HOLD; i++) begin
      if (core_reset) highs++;
      step();
    end
    check("empty_core_reset_held", 64'(highs), 64'(2 * HOLD));

    // Reset lands on byte 100 of a load; the still-high download restarts it.
    ioctl_index = 8'd0; ioctl_download = 1'b1;
    repeat (3) step();
    for (int i = 0; i < 100; i++) drive_byte(25'(i), 8'(i));
    reset_n = 1'b0;
    drive_byte(25'd100, 8'd100);
    check_reset_vals("midrst");
    reset_n = 1'b1;
    repeat (3) step();
    check("midrst_rom_dl",     64'(rom_download), 64'd1);
    check("midrst_rom_bytes0", 64'(rom_bytes), 64'd0);
    check("midrst_core_reset", 64'(core_reset), 64'd1);
    for (int i = 0; i < 5; i++) drive_byte(25'(i), 8'(8'hC0 + 8'(i)));
    step();
    check("midrst_rom_bytes5", 64'(rom_bytes), 64'd5);
    ioctl_download = 1'b0;
    check_pulse("midrst", -1);
    check("midrst_rom_loaded", 64'(rom_loaded), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
